// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared RV32I immediate format enum, NOP and opcode constants
package imm_encoder_pkg;

  // Instruction format selector shared by the encoder and the decoder
  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_U  = 3'd1,
    FMT_S  = 3'd2,
    FMT_R  = 3'd3,
    FMT_SB = 3'd4,
    FMT_UJ = 3'd5
  } imm_fmt_e;

  // addi x0, x0, 0 : emitted whenever the request cannot be encoded
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Base opcodes
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - flags immediates the selected format cannot represent
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  output logic        o_err
);

  logic w_sext11;
  logic w_sext12;
  logic w_sext20;

  // A field is representable when all bits above its sign bit copy the sign bit
  assign w_sext11 = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign w_sext12 = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign w_sext20 = (&i_imm[31:20]) || !(|i_imm[31:20]);

  // Per-format range rule; unknown formats always fail
  always_comb begin
    o_err = 1'b1;
    case (imm_fmt_e'(i_fmt))
      FMT_I, FMT_S: o_err = !w_sext11;
      FMT_SB:       o_err = !w_sext12 || i_imm[0];
      FMT_UJ:       o_err = !w_sext20 || i_imm[0];
      FMT_U:        o_err = |i_imm[11:0];
      FMT_R:        o_err = 1'b0;
      default:      o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready RV32I instruction word encoder
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 holding registers
  logic        r_s1_valid;
  logic        r_s1_err;
  logic [2:0]  r_s1_fmt;
  logic [6:0]  r_s1_op;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [2:0]  r_s1_f3;
  logic [6:0]  r_s1_f7;
  logic [31:0] r_s1_imm;

  // Stage 2 / output registers
  logic             r_s2_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  logic        w_s2_load;
  logic        w_s1_load;
  logic        w_fire;
  logic        w_range_err;
  logic [31:0] w_packed;

  // Stall propagates backwards combinationally; no skid buffer
  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_fire    = r_s2_valid && out_ready;

  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

  imm_range_check u_range_check (
    .i_fmt (in_fmt),
    .i_imm (in_imm),
    .o_err (w_range_err)
  );

  // Stage 1: capture the request and its range verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_fmt   <= 3'd0;
      r_s1_op    <= 7'd0;
      r_s1_rd    <= 5'd0;
      r_s1_rs1   <= 5'd0;
      r_s1_rs2   <= 5'd0;
      r_s1_f3    <= 3'd0;
      r_s1_f7    <= 7'd0;
      r_s1_imm   <= 32'd0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_err <= w_range_err;
        r_s1_fmt <= in_fmt;
        r_s1_op  <= in_opcode;
        r_s1_rd  <= in_rd;
        r_s1_rs1 <= in_rs1;
        r_s1_rs2 <= in_rs2;
        r_s1_f3  <= in_funct3;
        r_s1_f7  <= in_funct7;
        r_s1_imm <= in_imm;
      end
    end
  end

  // Scatter the immediate into the format's bit positions; errors become a NOP
  always_comb begin
    w_packed = NOP_INSTR;
    if (!r_s1_err) begin
      case (imm_fmt_e'(r_s1_fmt))
        FMT_I:  w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        FMT_U:  w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
        FMT_S:  w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:0], r_s1_op};
        FMT_R:  w_packed = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
        FMT_SB: w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
        FMT_UJ: w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                            r_s1_imm[19:12], r_s1_rd, r_s1_op};
        default: w_packed = NOP_INSTR;
      endcase
    end
  end

  // Stage 2: register the packed word and hold it while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr <= w_packed;
        r_out_err   <= r_s1_err;
      end
    end
  end

  // Saturating delivery counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_fire) begin
      if (r_enc_count != CNT_MAX) r_enc_count <= r_enc_count + 1'b1;
      if (r_out_err && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] dimm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  bit   saw_backpressure = 0;
  bit   stalled_prev = 0;
  logic [31:0] held_instr;
  logic        held_err;

  imm_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference encoder written straight from the format tables
  function automatic logic [32:0] model_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic        e;
    logic [31:0] w;
    e = 1'b0;
    w = 32'h0;
    case (f)
      3'd0: begin e = (imm[31:11] != {21{imm[11]}}); w = {imm[11:0], rs1, f3, rd, op}; end
      3'd1: begin e = (imm[11:0] != 12'h0); w = {imm[31:12], rd, op}; end
      3'd2: begin e = (imm[31:11] != {21{imm[11]}}); w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3'd3: begin e = 1'b0; w = {f7, rs2, rs1, f3, rd, op}; end
      3'd4: begin
        e = (imm[31:12] != {20{imm[12]}}) || imm[0];
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      3'd5: begin
        e = (imm[31:20] != {12{imm[20]}}) || imm[0];
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
    return {e, w};
  endfunction

  // Immediate decoder as used on the fetch side
  function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] i);
    case (f)
      3'd0: return {{20{i[31]}}, i[31:20]};
      3'd1: return {i[31:12], 12'h0};
      3'd2: return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd4: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd5: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Present one request (starting just after a rising edge) and wait for acceptance
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    exp_t e;
    int   k;
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    e.instr = ei; e.err = ee; e.fmt = f; e.dimm = (f == 3'd3) ? 32'h0 : imm;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    else sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [32:0] m;
    m = model_enc(f, op, rd, rs1, rs2, f3, f7, imm);
    send(f, op, rd, rs1, rs2, f3, f7, imm, m[31:0], m[32]);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: scoreboard pops, stall-stability and backpressure observation
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (in_valid && !in_ready) saw_backpressure = 1'b1;
      if (stalled_prev) begin
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_instr", out_instr, held_instr);
        check_eq("stall_err", 32'(out_err), 32'(held_err));
      end
      stalled_prev = out_valid && !out_ready;
      held_instr = out_instr;
      held_err = out_err;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_output", out_instr, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_popped++;
          check_eq("instr", out_instr, e.instr);
          check_eq("err", 32'(out_err), 32'(e.err));
          if (!e.err) check_eq("decoded_imm", decode_imm(e.fmt, out_instr), e.dimm);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    bit   done;
    logic [31:0] r;
    logic [2:0]  f;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_out_err", 32'(out_err), 32'd0);
    check_eq("rst_enc_count", 32'(enc_count), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: I-type with latency check
    begin
      exp_t e;
      in_valid = 1'b1; in_fmt = 3'd0; in_opcode = 7'h13; in_rd = 5'd1; in_rs1 = 5'd0;
      in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'hFFFF_FFFF;
      e.instr = 32'hFFF0_0093; e.err = 1'b0; e.fmt = 3'd0; e.dimm = 32'hFFFF_FFFF;
      sb_q.push_back(e);
      @(negedge clk);
      check_eq("t1_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("t1_lat_cycle1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check_eq("t1_lat_cycle2", 32'(out_valid), 32'd1);
      check_eq("t1_instr_direct", out_instr, 32'hFFF0_0093);
    end
    drain();

    // Test 2: SB, UJ, U directed words
    send(3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0008, 32'h0000_0463, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send(3'd1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    drain();

    // Test 3: out-of-range immediates and illegal format
    send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    send(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);
    drain();
    check_eq("t3_err_count", 32'(err_count), 32'd3);
    check_eq("t3_enc_count", 32'(enc_count), 32'd7);

    // Test 4: back-to-back burst with a 3-cycle consumer stall
    do_reset();
    base = n_popped;
    saw_backpressure = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_model(3'd0, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'(i), 7'd0, 32'(i * 37 - 100));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t4_backpressure", 32'(saw_backpressure), 32'd1);
    check_eq("t4_delivered", 32'(n_popped - base), 32'd8);
    check_eq("t4_enc_count", 32'(enc_count), 32'd8);
    check_eq("t4_err_count", 32'(err_count), 32'd0);

    // Test 5: reset with both stages full
    out_ready = 1'b0;
    send(3'd3, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 32'h0031_00B3, 1'b0);
    send(3'd3, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0, 32'h0062_8233, 1'b0);
    check_eq("t5_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("t5_full_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t5_out_valid", 32'(out_valid), 32'd0);
    check_eq("t5_enc_count", 32'(enc_count), 32'd0);
    check_eq("t5_err_count", 32'(err_count), 32'd0);
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t5_no_stale", 32'(out_valid), 32'd0);

    // Test 6: random in-range requests with random consumer stalls
    done = 1'b0;
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          r = $urandom;
          f = 3'($urandom_range(0, 5));
          case (f)
            3'd0, 3'd2: in_imm = {{20{r[11]}}, r[11:0]};
            3'd1:       in_imm = {r[31:12], 12'h0};
            3'd4:       in_imm = {{19{r[12]}}, r[12:1], 1'b0};
            3'd5:       in_imm = {{11{r[20]}}, r[20:1], 1'b0};
            default:    in_imm = r;
          endcase
          send_model(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), in_imm);
          if (($urandom_range(0, 4)) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t6_delivered", 32'(n_popped - base), 32'd60);
    check_eq("t6_err_count", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
